// File: rtl/vga_ctrl.sv
// VGA raster timing generator: free-running h/v counters decoded into sync,
// blanking, active-area coordinates and a colour gate towards the DAC.
module vga_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_ACT   = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_ACT   = 480,
    parameter int V_FRONT = 10,
    parameter int COLOR_W = 10,
    parameter int COORD_W = 11
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic [COORD_W-1:0] oCurrent_X,
    output logic [COORD_W-1:0] oCurrent_Y,
    output logic               oRequest,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_CLOCK
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_off;
    logic [VW-1:0] v_off;
    logic          h_act;
    logic          v_act;
    logic          active;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == VW'(V_TOTAL - 1))
                v_cnt <= '0;
            else
                v_cnt <= v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Inclusive upper bounds keep the compare constants inside the counter width.
    always_comb begin
        h_act  = (h_cnt >= HW'(H_START)) && (h_cnt <= HW'(H_START + H_ACT - 1));
        v_act  = (v_cnt >= VW'(V_START)) && (v_cnt <= VW'(V_START + V_ACT - 1));
        active = h_act && v_act;
        h_off  = h_cnt - HW'(H_START);
        v_off  = v_cnt - VW'(V_START);
    end

    always_comb begin
        oVGA_HS    = (h_cnt >= HW'(H_SYNC));
        oVGA_VS    = (v_cnt >= VW'(V_SYNC));
        oRequest   = active;
        oVGA_BLANK = active;
        oCurrent_X = active ? COORD_W'(h_off) : '0;
        oCurrent_Y = active ? COORD_W'(v_off) : '0;
        oVGA_R     = active ? iRed   : '0;
        oVGA_G     = active ? iGreen : '0;
        oVGA_B     = active ? iBlue  : '0;
        oVGA_CLOCK = ~iCLK;
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a full-size instance and a shrunken-timing instance run
// side by side against an arithmetic raster model plus a table of fixed points.
module tb_vga_ctrl;

    localparam int N_CYC  = 48000;
    localparam int RST_AT = 45000;
    localparam int N_TBL  = 13;

    // shrunken timing: 17 clocks per line, 12 lines per frame
    localparam int S_HS = 4, S_HB = 3, S_HA = 8, S_HF = 2;
    localparam int S_VS = 2, S_VB = 3, S_VA = 5, S_VF = 2;
    localparam int S_HT = S_HS + S_HB + S_HA + S_HF;
    localparam int S_VT = S_VS + S_VB + S_VA + S_VF;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
    } vid_t;

    typedef struct {
        int         t;
        logic [9:0] ri, gi, bi;
        vid_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] r_in = '0, g_in = '0, b_in = '0;

    logic [10:0] x_d, y_d, x_s, y_s;
    logic [9:0]  vr_d, vg_d, vb_d, vr_s, vg_s, vb_s;
    logic        req_d, hs_d, vs_d, blank_d, ck_d;
    logic        req_s, hs_s, vs_s, blank_s, ck_s;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vga_ctrl dut_d (
        .iCLK(clk), .iRST(rst), .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
        .oCurrent_X(x_d), .oCurrent_Y(y_d), .oRequest(req_d),
        .oVGA_R(vr_d), .oVGA_G(vg_d), .oVGA_B(vb_d),
        .oVGA_HS(hs_d), .oVGA_VS(vs_d), .oVGA_BLANK(blank_d), .oVGA_CLOCK(ck_d)
    );

    vga_ctrl #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_ACT(S_HA), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_ACT(S_VA), .V_FRONT(S_VF)
    ) dut_s (
        .iCLK(clk), .iRST(rst), .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
        .oCurrent_X(x_s), .oCurrent_Y(y_s), .oRequest(req_s),
        .oVGA_R(vr_s), .oVGA_G(vg_s), .oVGA_B(vb_s),
        .oVGA_HS(hs_s), .oVGA_VS(vs_s), .oVGA_BLANK(blank_s), .oVGA_CLOCK(ck_s)
    );

    // Position in the raster is just the clock count since reset, split by line/frame size.
    function automatic vid_t model(int hs, int hb, int ha, int hf, int vsy, int vb,
                                   int va, int vf, int t,
                                   logic [9:0] ri, logic [9:0] gi, logic [9:0] bi);
        vid_t m;
        int   ht, vt, h, v;
        bit   act;
        ht = hs + hb + ha + hf;
        vt = vsy + vb + va + vf;
        h  = t % ht;
        v  = (t / ht) % vt;
        act = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vsy + vb) && (v < vsy + vb + va);
        m.hs    = (h >= hs);
        m.vs    = (v >= vsy);
        m.blank = act;
        m.req   = act;
        m.x     = act ? 11'(h - hs - hb) : '0;
        m.y     = act ? 11'(v - vsy - vb) : '0;
        m.r     = act ? ri : '0;
        m.g     = act ? gi : '0;
        m.b     = act ? bi : '0;
        return m;
    endfunction

    function automatic vec_t mk(int t, logic [9:0] ri, logic [9:0] gi, logic [9:0] bi,
                                logic hs, logic vs, logic act, int x, int y,
                                logic [9:0] er, logic [9:0] eg, logic [9:0] eb);
        vec_t e;
        e.t = t; e.ri = ri; e.gi = gi; e.bi = bi;
        e.exp.hs = hs; e.exp.vs = vs; e.exp.blank = act; e.exp.req = act;
        e.exp.x = 11'(x); e.exp.y = 11'(y);
        e.exp.r = er; e.exp.g = eg; e.exp.b = eb;
        return e;
    endfunction

    task automatic chk_vid(string name, int t, vid_t got, vid_t exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
    endtask

    task automatic chk_int(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    initial begin
        vec_t tbl[N_TBL];
        vid_t got_d, got_s, exp_d, exp_s;
        int   t, tbl_idx;
        bit   mid_done;
        logic ck_hi_s, ck_hi_d;
        // shrunken-instance frame statistics
        logic s_prev_hs, s_prev_vs;
        int   s_last_fall, s_hs_falls, s_reqs, s_vs_low;
        bit   s_frame_on;
        // full-size line statistics
        logic d_prev_hs;
        int   d_last_fall;

        tbl[0]  = mk(0,     10'h3FF, 10'h3FF, 10'h3FF, 0, 0, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[1]  = mk(95,    10'h3FF, 10'h3FF, 10'h3FF, 0, 0, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[2]  = mk(96,    10'h3FF, 10'h3FF, 10'h3FF, 1, 0, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[3]  = mk(100,   10'h3FF, 10'h3FF, 10'h3FF, 1, 0, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[4]  = mk(1599,  10'h3FF, 10'h3FF, 10'h3FF, 1, 0, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[5]  = mk(1600,  10'h3FF, 10'h3FF, 10'h3FF, 0, 1, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[6]  = mk(28143, 10'h3FF, 10'h3FF, 10'h3FF, 1, 1, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[7]  = mk(28144, 10'h3FF, 10'h3FF, 10'h3FF, 1, 1, 1, 0,   0,  10'h3FF, 10'h3FF, 10'h3FF);
        tbl[8]  = mk(28783, 10'h3FF, 10'h3FF, 10'h3FF, 1, 1, 1, 639, 0,  10'h3FF, 10'h3FF, 10'h3FF);
        tbl[9]  = mk(28784, 10'h3FF, 10'h3FF, 10'h3FF, 1, 1, 0, 0,   0,  10'h000, 10'h000, 10'h000);
        tbl[10] = mk(29244, 10'h000, 10'h3FF, 10'h0CC, 1, 1, 1, 300, 1,  10'h000, 10'h3FF, 10'h0CC);
        tbl[11] = mk(29294, 10'h000, 10'h3FF, 10'h0CC, 1, 1, 1, 350, 1,  10'h000, 10'h3FF, 10'h0CC);
        tbl[12] = mk(40267, 10'h155, 10'h2AA, 10'h001, 1, 1, 1, 123, 15, 10'h155, 10'h2AA, 10'h001);

        t = 0; tbl_idx = 0; mid_done = 0;
        s_prev_hs = 1; s_prev_vs = 1; s_last_fall = -1;
        s_hs_falls = 0; s_reqs = 0; s_vs_low = 0; s_frame_on = 0;
        d_prev_hs = 1; d_last_fall = -1;

        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk);
            if (rst) begin
                t = 0;
                if (n > 2) mid_done = 1;
                s_prev_hs = 1; s_prev_vs = 1; s_last_fall = -1; s_frame_on = 0;
                d_prev_hs = 1; d_last_fall = -1;
            end else begin
                t = t + 1;
            end
            #1;
            rst = (n < 2) || (n == RST_AT);
            if (!mid_done && tbl_idx < N_TBL && t == tbl[tbl_idx].t) begin
                r_in = tbl[tbl_idx].ri; g_in = tbl[tbl_idx].gi; b_in = tbl[tbl_idx].bi;
            end else if (!mid_done && t >= 29244 && t <= 29294) begin
                r_in = 10'h000; g_in = 10'h3FF; b_in = 10'h0CC;
            end else begin
                r_in = 10'($urandom); g_in = 10'($urandom); b_in = 10'($urandom);
            end
            #2;
            got_d = {hs_d, vs_d, blank_d, req_d, x_d, y_d, vr_d, vg_d, vb_d};
            got_s = {hs_s, vs_s, blank_s, req_s, x_s, y_s, vr_s, vg_s, vb_s};
            exp_d = model(96, 48, 640, 16, 2, 33, 480, 10, t, r_in, g_in, b_in);
            exp_s = model(S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF, t, r_in, g_in, b_in);
            chk_vid("model_full", t, got_d, exp_d);
            chk_vid("model_small", t, got_s, exp_s);
            if (!mid_done && tbl_idx < N_TBL && t == tbl[tbl_idx].t) begin
                chk_vid("table_full", t, got_d, tbl[tbl_idx].exp);
                tbl_idx++;
            end

            if (s_prev_vs && !vs_s) begin
                if (s_frame_on) begin
                    chk_int("small_lines_per_frame", s_hs_falls, S_VT);
                    chk_int("small_req_per_frame", s_reqs, S_HA * S_VA);
                    chk_int("small_vs_low_clocks", s_vs_low, S_VS * S_HT);
                end
                s_frame_on = 1; s_hs_falls = 0; s_reqs = 0; s_vs_low = 0;
            end
            if (s_prev_hs && !hs_s) begin
                if (s_last_fall >= 0) chk_int("small_hs_period", n - s_last_fall, S_HT);
                s_last_fall = n;
                s_hs_falls++;
            end
            if (req_s) s_reqs++;
            if (!vs_s) s_vs_low++;
            s_prev_hs = hs_s; s_prev_vs = vs_s;

            if (d_prev_hs && !hs_d) begin
                if (d_last_fall >= 0) chk_int("full_hs_period", n - d_last_fall, 800);
                d_last_fall = n;
            end
            if (!d_prev_hs && hs_d && d_last_fall >= 0)
                chk_int("full_hs_low", n - d_last_fall, 96);
            d_prev_hs = hs_d;

            ck_hi_s = ck_s; ck_hi_d = ck_d;
            #5;
            n_total++;
            if ({ck_hi_s, ck_hi_d, ck_s, ck_d} === 4'b0011) n_pass++;
            else $display("FAIL dac_clock t=%0d got=%b expected=0011", t,
                          {ck_hi_s, ck_hi_d, ck_s, ck_d});
        end

        chk_int("table_rows_applied", tbl_idx, N_TBL);
        chk_int("mid_frame_reset_seen", int'(mid_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA raster timing generator and pixel gate; default 640x480 @ 60 Hz with a 25 MHz pixel clock.
- Produces HS/VS/BLANK, the current active-pixel coordinates and a pixel-request strobe to the host pixel generator.
- Passes host RGB to the DAC during active video and forces black elsewhere.
- Sits between the frame/sprite drawing logic and the board's video DAC.

Parameters:
- H_SYNC, 96, horizontal sync pulse width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACT, 480, active lines
- V_FRONT, 10, vertical front porch in lines
- COLOR_W, 10, bits per colour channel
- COORD_W, 11, coordinate output width

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  synchronous reset, active high
- iRed  in  COLOR_W  host red for the current pixel
- iGreen  in  COLOR_W  host green
- iBlue  in  COLOR_W  host blue
- oCurrent_X  out  COORD_W  active-area column, 0..H_ACT-1
- oCurrent_Y  out  COORD_W  active-area row, 0..V_ACT-1
- oRequest  out  1  high while the current pixel is in the active area
- oVGA_R  out  COLOR_W  red to DAC
- oVGA_G  out  COLOR_W  green to DAC
- oVGA_B  out  COLOR_W  blue to DAC
- oVGA_HS  out  1  horizontal sync, active low
- oVGA_VS  out  1  vertical sync, active low
- oVGA_BLANK  out  1  DAC blank_n: high in active video, low in blanking
- oVGA_CLOCK  out  1  DAC clock, equal to inverted iCLK

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT (800).
  - V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT (525).
  - H_START = H_SYNC + H_BACK (144).
  - V_START = V_SYNC + V_BACK (35).
- Counters: h_cnt and v_cnt are registered and sized to hold H_TOTAL-1 and V_TOTAL-1.
- Reset: iRST sampled high at a rising edge sets h_cnt = 0 and v_cnt = 0. Reset takes priority over counting, including when asserted mid-frame.
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0.
- v_cnt increments only on the cycle where h_cnt wraps. v_cnt wraps to 0 when h_cnt wraps while v_cnt = V_TOTAL-1.
- All other outputs are combinational decodes of the registered counters and the inputs. There is zero latency from counter state to outputs.
- oVGA_HS = 0 when h_cnt < H_SYNC, else 1.
- oVGA_VS = 0 when v_cnt < V_SYNC, else 1.
- Active area is h_cnt in [H_START, H_START+H_ACT-1] and v_cnt in [V_START, V_START+V_ACT-1].
- In the active area:
  - oRequest = 1 and oVGA_BLANK = 1.
  - oCurrent_X = h_cnt - H_START and oCurrent_Y = v_cnt - V_START, zero-extended to COORD_W.
- Outside the active area:
  - oRequest = 0, oVGA_BLANK = 0.
  - oCurrent_X = 0, oCurrent_Y = 0.
- oVGA_R/G/B = iRed/iGreen/iBlue when oRequest = 1, else all zeros. No clipping or scaling.
- oVGA_CLOCK = ~iCLK, unconditionally, including during reset.
- Values during and immediately after reset (counters = 0):
  - oVGA_HS = 0, oVGA_VS = 0.
  - oRequest = 0, oVGA_BLANK = 0.
  - Coordinates 0, RGB 0.
- Frame period is H_TOTAL*V_TOTAL = 420000 clocks. HS period is 800 clocks. VS low time is 2*800 = 1600 clocks.
- Host contract: the host supplies the colour for (oCurrent_X, oCurrent_Y) in the same cycle. A registered host that uses the coordinates therefore lands one pixel to the right, which is acceptable.

Test Plan:
- Reset held 3 cycles, then released:
  - cycle 0: HS=0, VS=0, BLANK=0, oRequest=0, RGB=0.
  - HS stays 0 for 96 clocks, then HS=1 at h_cnt=96.
- Line/frame counting:
  - Count clocks between HS falling edges: exactly 800.
  - Count HS falling edges between VS falling edges: exactly 525.
  - VS low for exactly 1600 clocks.
- Active window with iRed=iGreen=iBlue=10'h3FF:
  - First cycle with oRequest=1 is h_cnt=144, v_cnt=35: X=0, Y=0, RGB=3FF, BLANK=1.
  - Last is h_cnt=783, v_cnt=514: X=639, Y=479.
  - Exactly 640 request cycles per active line and 480 active lines per frame (307200 per frame).
- Blanking gate: inputs held 3FF, sampled at h_cnt=100 and at v_cnt=520 -> RGB=0, X=0, Y=0, oRequest=0, BLANK=0.
- Pass-through: in the active area, drive iRed=0, iGreen=3FF, iBlue=0CC at X=300..350 -> DAC outputs match the inputs in the same cycle.
- Mid-frame reset: assert iRST at v_cnt=200, h_cnt=400 for 1 cycle -> next cycle h_cnt=1, v_cnt=0. The timing sequence restarts identically to the first test. oVGA_CLOCK toggles throughout.
